// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: opcodes, ALU op codes and FSM state encoding shared by the ALU sharing controller
package alu_share_ctrl_pkg;
   localparam int DATA_W = 8;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;
   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SLL = 1'b1;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: two request channels and the tagged response channel of the ALU sharing controller
interface alu_share_ctrl_if;
   import alu_share_ctrl_pkg::*;
   logic              req0_valid;
   logic              req0_ready;
   logic [1:0]        req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [1:0]        req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [2*DATA_W-1:0] rsp_data;
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
   );
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer favours the requester not granted last, req0 after reset
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);
   logic ptr_q, ptr_d;
   // a lone valid wins outright; on a tie the pointer decides, and an accepted grant hands priority to the other side
   always_comb begin
      grant[0] = valid[0] & (~valid[1] | ~ptr_q);
      grant[1] = valid[1] & (~valid[0] | ptr_q);
      ptr_d = advance ? grant[0] : ptr_q;
   end
   // pointer register
   always_ff @(posedge clk) begin
      ptr_q <= rst ? 1'b0 : ptr_d;
   end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one 8-bit ALU, runs ADD/SLL in one pass and MUL as 8 shift-add passes
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int MUL_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_ctrl_if.slave   bus,
   output logic              busy,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_cout
);
   localparam bit MUL_ON = (MUL_EN != 0);
   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic                id_q, id_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [2*DATA_W-1:0] data_q, data_d;
   logic [1:0]          grant;
   logic                rsv, mul_c;
   logic [DATA_W-1:0]   mul_hi;
   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   ({bus.req1_valid, bus.req0_valid} & {2{state_q == S_IDLE && !rst}}),
      .advance (|grant),
      .grant   (grant)
   );
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.rsp_valid  = state_q == S_RESP;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_data   = data_q;
   assign busy           = state_q != S_IDLE;
   assign rsv            = op_q == OP_RSV || (op_q == OP_MUL && !MUL_ON);
   // next state, operand capture, multiply iteration and ALU drive
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = ALU_ADD;
      mul_c   = 1'b0;
      mul_hi  = '0;
      case (state_q)
         S_IDLE: if (|grant) begin
            op_d    = grant[1] ? bus.req1_op : bus.req0_op;
            a_d     = grant[1] ? bus.req1_a : bus.req0_a;
            b_d     = grant[1] ? bus.req1_b : bus.req0_b;
            id_d    = grant[1];
            hi_d    = '0;
            lo_d    = b_d;
            cnt_d   = '0;
            state_d = (op_d == OP_MUL && MUL_ON) ? S_MUL : S_EXEC;
         end
         S_EXEC: begin
            alu_a   = rsv ? '0 : a_q;
            alu_b   = rsv ? '0 : b_q;
            alu_op  = rsv ? ALU_ADD : op_q[0];
            data_d  = rsv ? '0 : {7'b0, alu_cout, alu_out};
            state_d = S_RESP;
         end
         S_MUL: begin
            alu_a   = hi_q;
            alu_b   = a_q;
            {mul_c, mul_hi} = lo_q[0] ? {alu_cout, alu_out} : {1'b0, hi_q};
            {hi_d, lo_d}    = {mul_c, mul_hi, lo_q[DATA_W-1:1]};
            cnt_d   = cnt_q + 3'd1;
            data_d  = (cnt_q == 3'd7) ? {hi_d, lo_d} : data_q;
            state_d = (cnt_q == 3'd7) ? S_RESP : S_MUL;
         end
         S_RESP: state_d = bus.rsp_ready ? S_IDLE : S_RESP;
         default: state_d = S_IDLE;
      endcase
   end
   // state and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, ADD/SLL/MUL results, latency, back-pressure and reset abort
module tb_alu_share_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       busy, alu_op, alu_cout;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [8:0] alu_res;
   int         total = 0;
   int         bad = 0;
   alu_share_ctrl_if bus ();
   alu_share_ctrl #(.MUL_EN(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_out  (alu_out),
      .alu_cout (alu_cout)
   );
   always #5 clk = ~clk;
   always_comb alu_res = alu_op ? ({1'b0, alu_a} << alu_b) : ({1'b0, alu_a} + {1'b0, alu_b});
   assign alu_out  = alu_res[7:0];
   assign alu_cout = alu_res[8];
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end
      #1;
      chk(id ? "issue_rdy1" : "issue_rdy0", {15'b0, id ? bus.req1_ready : bus.req0_ready}, 16'h1);
      tick;
      if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
      bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
      bus.rsp_ready = 1'b1;
      tick;
      tick;
      chk("rst_busy", {15'b0, busy}, 16'h0);
      chk("rst_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("rst_rsp_id", {15'b0, bus.rsp_id}, 16'h0);
      chk("rst_rsp_data", bus.rsp_data, 16'h0);
      chk("rst_alu", {alu_a, alu_b[6:0], alu_op}, 16'h0);
      chk("rst_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'h0);
      rst = 1'b0;
      tick;
      issue(1'b0, 2'b00, 8'hF0, 8'h20);
      chk("add_t1_busy", {15'b0, busy}, 16'h1);
      chk("add_t1_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("add_t1_alu", {alu_a, alu_b}, 16'hF020);
      chk("add_t1_alu_op", {15'b0, alu_op}, 16'h0);
      tick;
      chk("add_t2_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("add_rsp_data", bus.rsp_data, 16'h0110);
      chk("add_rsp_id", {15'b0, bus.rsp_id}, 16'h0);
      tick;
      chk("add_done_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("add_done_busy", {15'b0, busy}, 16'h0);
      issue(1'b1, 2'b01, 8'h81, 8'h01);
      chk("sll_alu_op", {15'b0, alu_op}, 16'h1);
      tick;
      chk("sll1_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("sll1_rsp_data", bus.rsp_data, 16'h0102);
      chk("sll1_rsp_id", {15'b0, bus.rsp_id}, 16'h1);
      tick;
      issue(1'b1, 2'b01, 8'h81, 8'h09);
      tick;
      chk("sll9_rsp_data", bus.rsp_data, 16'h0000);
      tick;
      issue(1'b0, 2'b10, 8'hFF, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         chk("mul_alu_op", {15'b0, alu_op}, 16'h0);
         chk("mul_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
         chk("mul_alu_b", {8'h0, alu_b}, 16'h00FF);
         tick;
      end
      chk("mul_t9_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("mul_ff_data", bus.rsp_data, 16'hFE01);
      chk("mul_ff_id", {15'b0, bus.rsp_id}, 16'h0);
      tick;
      issue(1'b1, 2'b10, 8'h0D, 8'h0B);
      repeat (8) tick;
      chk("mul_db_valid", {15'b0, bus.rsp_valid}, 16'h1);
      chk("mul_db_data", bus.rsp_data, 16'h008F);
      chk("mul_db_id", {15'b0, bus.rsp_id}, 16'h1);
      tick;
      bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 8'h01; bus.req0_b = 8'h01;
      bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 8'h02; bus.req1_b = 8'h03;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready", {14'b0, bus.req1_ready, bus.req0_ready}, (k % 2 == 0) ? 16'h1 : 16'h2);
         tick;
         tick;
         chk("rr_rsp_id", {15'b0, bus.rsp_id}, (k % 2 == 0) ? 16'h0 : 16'h1);
         chk("rr_rsp_data", bus.rsp_data, (k % 2 == 0) ? 16'h0002 : 16'h0005);
         tick;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      issue(1'b0, 2'b00, 8'h07, 8'h09);
      bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 8'h03; bus.req1_b = 8'h04;
      tick;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid", {15'b0, bus.rsp_valid}, 16'h1);
         chk("stall_rsp_data", bus.rsp_data, 16'h0010);
         chk("stall_rsp_id", {15'b0, bus.rsp_id}, 16'h0);
         chk("stall_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'h0);
         tick;
      end
      bus.rsp_ready = 1'b1;
      tick;
      chk("stall_release_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("stall_release_rdy1", {15'b0, bus.req1_ready}, 16'h1);
      tick;
      bus.req1_valid = 1'b0;
      bus.req1_a = 8'hAA;
      tick;
      chk("pending_rsp_id", {15'b0, bus.rsp_id}, 16'h1);
      chk("pending_rsp_data", bus.rsp_data, 16'h0007);
      tick;
      issue(1'b0, 2'b10, 8'h0D, 8'h0B);
      repeat (4) tick;
      chk("abort_pre_busy", {15'b0, busy}, 16'h1);
      rst = 1'b1;
      tick;
      chk("abort_busy", {15'b0, busy}, 16'h0);
      chk("abort_rsp_valid", {15'b0, bus.rsp_valid}, 16'h0);
      chk("abort_alu", {alu_a, alu_b[6:0], alu_op}, 16'h0);
      chk("abort_alu_b7", {15'b0, alu_b[7]}, 16'h0);
      chk("abort_rsp_data", bus.rsp_data, 16'h0);
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 8'h05; bus.req0_b = 8'h06;
      bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 8'h01; bus.req1_b = 8'h01;
      #1;
      chk("post_rst_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'h1);
      tick;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick;
      chk("post_rst_rsp_id", {15'b0, bus.rsp_id}, 16'h0);
      chk("post_rst_rsp_data", bus.rsp_data, 16'h000B);
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
